// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read side and muldiv_unit.
// Signal prefixes are from the unit's point of view: i_ flows into the unit, o_ flows out.
interface muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [3:0]       i_wa_in;
  logic             o_busy;
  logic             o_done;
  logic             o_we;
  logic [3:0]       o_wa;
  logic [WIDTH-1:0] o_result;
  logic             o_div0;

  modport master (
    output i_start, i_op, i_a, i_b, i_wa_in,
    input  o_busy, o_done, o_we, o_wa, o_result, o_div0
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_wa_in,
    output o_busy, o_done, o_we, o_wa, o_result, o_div0
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed mul/div/mod for HMMM: fixed WIDTH+2 cycle latency, floor-semantics division.
// Define MULDIV_DIV_EN to build the divider; without it div/mod report div0 and never write back.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [1:0]    OP_DIV  = 2'b01;
  localparam logic [1:0]    OP_MOD  = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [3:0]       r_wa;
  logic             r_signA;
  logic             r_signB;
  logic [WIDTH-1:0] r_magA;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic             r_div0;

  logic             w_isDiv;
  logic             w_isDivIn;
  logic             w_differ;
  logic [WIDTH-1:0] w_magAIn;
  logic [WIDTH-1:0] w_magBIn;
  logic [WIDTH-1:0] w_mulRes;
  logic [WIDTH-1:0] w_fixResult;
  logic             w_fixDiv0;
  logic             w_weAllowed;

  assign w_isDiv   = (r_op == OP_DIV) || (r_op == OP_MOD);
  assign w_isDivIn = (bus.i_op == OP_DIV) || (bus.i_op == OP_MOD);
  assign w_differ  = r_signA ^ r_signB;
  assign w_magAIn  = bus.i_a[WIDTH-1] ? -bus.i_a : bus.i_a;
  assign w_magBIn  = bus.i_b[WIDTH-1] ? -bus.i_b : bus.i_b;
  // Low WIDTH bits of the magnitude product, negated mod 2^WIDTH, equal the wrapped signed product.
  assign w_mulRes  = w_differ ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] r_magB;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_bVal;
  logic [WIDTH-1:0] w_remTrunc;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_adjust;

  // Restoring step plus the truncated-to-floor correction applied in FIX.
  always_comb begin
    w_shifted  = {r_acc, r_work[WIDTH-1]};
    w_trial    = w_shifted - {1'b0, r_magB};
    w_remNext  = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_bVal     = r_signB ? -r_magB : r_magB;
    w_remTrunc = r_signA ? -r_acc : r_acc;
    w_adjust   = w_differ && (r_acc != '0);
    w_quo      = r_work;
    w_rem      = w_remTrunc;
    if (w_adjust) begin
      w_quo = ~r_work;
      w_rem = w_remTrunc + w_bVal;
    end else if (w_differ) begin
      w_quo = -r_work;
    end
  end
`endif

  always_comb begin
    w_fixResult = w_mulRes;
    w_fixDiv0   = 1'b0;
    if (w_isDiv) begin
`ifdef MULDIV_DIV_EN
      if (r_magB == '0) begin
        w_fixResult = '0;
        w_fixDiv0   = 1'b1;
      end else if (r_op == OP_MOD) begin
        w_fixResult = w_rem;
      end else begin
        w_fixResult = w_quo;
      end
`else
      w_fixResult = '0;
      w_fixDiv0   = 1'b1;
`endif
    end
  end

`ifdef MULDIV_DIV_EN
  assign w_weAllowed = 1'b1;
`else
  assign w_weAllowed = !w_isDiv;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_next = CALC;
      CALC:    if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy = (r_state != IDLE);
    bus.o_done = (r_state == DONE);
    bus.o_we   = (r_state == DONE) && (r_wa != 4'd0) && w_weAllowed;
  end

  assign bus.o_result = r_result;
  assign bus.o_wa     = r_wa;
  assign bus.o_div0   = r_div0;

  // r_work holds the multiplier (shifting right) for mul, or dividend-becoming-quotient for div/mod.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_wa     <= '0;
      r_signA  <= 1'b0;
      r_signB  <= 1'b0;
      r_magA   <= '0;
      r_acc    <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_div0   <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_magB   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_cnt   <= '0;
            r_op    <= bus.i_op;
            r_wa    <= bus.i_wa_in;
            r_signA <= bus.i_a[WIDTH-1];
            r_signB <= bus.i_b[WIDTH-1];
            r_magA  <= w_magAIn;
            r_acc   <= '0;
            r_work  <= w_isDivIn ? w_magAIn : w_magBIn;
`ifdef MULDIV_DIV_EN
            r_magB  <= w_magBIn;
`endif
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_isDiv) begin
            if (r_work[0]) r_acc <= r_acc + r_magA;
            r_magA <= r_magA << 1;
            r_work <= r_work >> 1;
          end
`ifdef MULDIV_DIV_EN
          else begin
            r_acc  <= w_remNext;
            r_work <= {r_work[WIDTH-2:0], ~w_trial[WIDTH]};
          end
`endif
        end
        FIX: begin
          r_result <= w_fixResult;
          r_div0   <= w_fixDiv0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results use floor division and follow MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 2;

  typedef struct packed {
    logic [15:0] result;
    logic        div0;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  lat;
  } rec_t;

  typedef struct packed {
    logic [15:0] result;
    logic        div0;
    logic        we;
    logic [3:0]  wa;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  wa;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycleCnt = 0;
  int   checks = 0;
  int   passes = 0;

  rec_t expQ[$];
  int   startQ[$];
  obs_t obsQ[$];

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Every done pulse is logged with the cycle it appeared in.
  always @(negedge clk) begin
    obs_t o;
    if (bus.o_done === 1'b1) begin
      o.result = bus.o_result;
      o.div0   = bus.o_div0;
      o.we     = bus.o_we;
      o.wa     = bus.o_wa;
      o.cyc    = cycleCnt;
      obsQ.push_back(o);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rec_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] wa);
    rec_t e;
    int   av;
    int   bv;
    int   q;
    int   r;
    av     = $signed(a);
    bv     = $signed(b);
    e.lat  = 8'(LAT);
    e.wa   = wa;
    e.div0 = 1'b0;
    e.we   = (wa != 4'd0);
    if (op == 2'd1 || op == 2'd2) begin
`ifdef MULDIV_DIV_EN
      if (bv == 0) begin
        e.result = 16'h0000;
        e.div0   = 1'b1;
      end else begin
        q = av / bv;
        r = av % bv;
        if (r != 0 && ((r < 0) != (bv < 0))) begin
          q = q - 1;
          r = r + bv;
        end
        e.result = (op == 2'd1) ? q[15:0] : r[15:0];
      end
`else
      e.result = 16'h0000;
      e.div0   = 1'b1;
      e.we     = 1'b0;
`endif
    end else begin
      q        = av * bv;
      e.result = q[15:0];
    end
    return e;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Raises start for the current cycle (cycle 0), then scrambles the operands.
  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] wa);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_wa_in = wa;
    startQ.push_back(cycleCnt);
    expQ.push_back(model(op, a, b, wa));
    @(negedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_op    = 2'($urandom);
    bus.i_a     = 16'($urandom);
    bus.i_b     = 16'($urandom);
    bus.i_wa_in = 4'($urandom);
  endtask

  task automatic waitObs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      if (obsQ.size() > 0) break;
      @(negedge clk);
      #1;
    end
    got = (obsQ.size() > 0);
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 2'd0;
    bus.i_a     = 16'h0;
    bus.i_b     = 16'h0;
    bus.i_wa_in = 4'd0;
    cycles(3);
    checks++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL reset_busy: actual=%b required=0", bus.o_busy); else passes++;
    checks++; if (bus.o_done !== 1'b0) $display("[TB] FAIL reset_done: actual=%b required=0", bus.o_done); else passes++;
    checks++; if (bus.o_we !== 1'b0) $display("[TB] FAIL reset_we: actual=%b required=0", bus.o_we); else passes++;
    checks++; if (bus.o_div0 !== 1'b0) $display("[TB] FAIL reset_div0: actual=%b required=0", bus.o_div0); else passes++;
    checks++; if (bus.o_wa !== 4'd0) $display("[TB] FAIL reset_wa: actual=%0d required=0", bus.o_wa); else passes++;
    checks++; if (bus.o_result !== 16'h0) $display("[TB] FAIL reset_result: actual=%h required=0000", bus.o_result); else passes++;
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_busy_timing;
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    issue(2'd0, 16'd300, 16'(-5), 4'd3);
    for (int k = 1; k <= LAT; k++) begin
      checks++;
      if ({bus.o_busy, bus.o_done} !== {1'b1, (k == LAT)})
        $display("[TB] FAIL busy_cycle%0d: actual busy=%b done=%b required busy=1 done=%b", k, bus.o_busy, bus.o_done, (k == LAT));
      else passes++;
      cycles(1);
    end
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_we} !== 3'b000)
      $display("[TB] FAIL after_done: actual busy=%b done=%b we=%b required 000", bus.o_busy, bus.o_done, bus.o_we);
    else passes++;
    waitObs(got);
    ex = expQ.pop_front();
    st = startQ.pop_front();
    checks++;
    if (!got) $display("[TB] FAIL mul_300x-5: actual=no done required=done within bound");
    else begin
      ob  = obsQ.pop_front();
      act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
      if (act !== ex || ex.result !== 16'hFA24)
        $display("[TB] FAIL mul_300x-5: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                 act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
      else passes++;
    end
    cycles(5);
    checks++;
    if ({bus.o_result, bus.o_wa} !== {16'hFA24, 4'd3})
      $display("[TB] FAIL hold_after_done: actual res=%h wa=%0d required res=fa24 wa=3", bus.o_result, bus.o_wa);
    else passes++;
  endtask

  task automatic test_mul;
    vec_t v[$];
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    v.push_back('{2'd0, 16'd256, 16'd256, 4'd1});
    v.push_back('{2'd0, 16'h8000, 16'(-1), 4'd2});
    v.push_back('{2'd0, 16'd3, 16'd4, 4'd4});
    v.push_back('{2'd0, 16'd0, 16'(-9), 4'd5});
    v.push_back('{2'd0, 16'(-1), 16'(-1), 4'd6});
    v.push_back('{2'd3, 16'd12, 16'(-12), 4'd7});
    for (int i = 0; i < 4; i++)
      v.push_back('{2'd0, 16'($urandom), 16'($urandom), 4'($urandom_range(1, 15))});
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].wa);
      waitObs(got);
      ex = expQ.pop_front();
      st = startQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL mul[%0d]: actual=no done required=done within bound", i);
      else begin
        ob  = obsQ.pop_front();
        act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
        if (act !== ex)
          $display("[TB] FAIL mul[%0d] %h*%h: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                   i, v[i].a, v[i].b, act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
        else passes++;
      end
      cycles(1);
    end
  endtask

  task automatic test_div;
    vec_t v[$];
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    v.push_back('{2'd1, 16'(-7), 16'd2, 4'd1});
    v.push_back('{2'd2, 16'(-7), 16'd2, 4'd2});
    v.push_back('{2'd1, 16'd7, 16'(-2), 4'd3});
    v.push_back('{2'd2, 16'd7, 16'(-2), 4'd4});
    v.push_back('{2'd1, 16'h8000, 16'(-1), 4'd5});
    v.push_back('{2'd2, 16'h8000, 16'(-1), 4'd6});
    v.push_back('{2'd1, 16'd9, 16'd3, 4'd7});
    v.push_back('{2'd1, 16'd5, 16'd0, 4'd8});
    v.push_back('{2'd2, 16'(-20), 16'(-6), 4'd9});
    v.push_back('{2'd1, 16'd0, 16'd5, 4'd10});
    for (int i = 0; i < 6; i++)
      v.push_back('{2'($urandom_range(1, 2)), 16'($urandom), 16'($urandom_range(1, 700)) ^ {16{i[0]}},
                    4'($urandom_range(1, 15))});
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].wa);
      waitObs(got);
      ex = expQ.pop_front();
      st = startQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL divmod[%0d]: actual=no done required=done within bound", i);
      else begin
        ob  = obsQ.pop_front();
        act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
        if (act !== ex)
          $display("[TB] FAIL divmod[%0d] op%0d %h,%h: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                   i, v[i].op, v[i].a, v[i].b, act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
        else passes++;
      end
      cycles(1);
    end
  endtask

  task automatic test_wa_zero;
    vec_t v[$];
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    v.push_back('{2'd0, 16'd5, 16'd5, 4'd0});
    v.push_back('{2'd1, 16'd5, 16'd0, 4'd0});
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].wa);
      waitObs(got);
      ex = expQ.pop_front();
      st = startQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL wa0[%0d]: actual=no done required=done within bound", i);
      else begin
        ob  = obsQ.pop_front();
        act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
        if (act !== ex)
          $display("[TB] FAIL wa0[%0d]: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                   i, act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
        else passes++;
      end
      cycles(1);
    end
  endtask

  task automatic test_ignore_start;
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    issue(2'd0, 16'd1000, 16'd7, 4'd5);
    cycles(4);
    bus.i_start = 1'b1; bus.i_op = 2'd1; bus.i_a = 16'd100; bus.i_b = 16'd3; bus.i_wa_in = 4'd9;
    cycles(1);
    bus.i_start = 1'b0;
    cycles(12);
    bus.i_start = 1'b1; bus.i_op = 2'd0; bus.i_a = 16'd2; bus.i_b = 16'd2; bus.i_wa_in = 4'd1;
    cycles(1);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0) $display("[TB] FAIL ignore_busy_c19: actual=%b required=0", bus.o_busy); else passes++;
    waitObs(got);
    ex = expQ.pop_front();
    st = startQ.pop_front();
    checks++;
    if (!got) $display("[TB] FAIL ignore_first: actual=no done required=done within bound");
    else begin
      ob  = obsQ.pop_front();
      act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
      if (act !== ex)
        $display("[TB] FAIL ignore_first: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                 act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
      else passes++;
    end
    cycles(2 * LAT);
    checks++;
    if ({bus.o_busy, (obsQ.size() != 0)} !== 2'b00)
      $display("[TB] FAIL ignore_no_extra: actual busy=%b extra_done=%0d required busy=0 extra_done=0", bus.o_busy, obsQ.size());
    else passes++;
  endtask

  task automatic test_reset_abort;
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    issue(2'd0, 16'd123, 16'd45, 4'd6);
    cycles(9);
    reset = 1'b1;
    cycles(1);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_we, bus.o_div0, bus.o_wa, bus.o_result} !== 24'h0)
      $display("[TB] FAIL abort_outputs: actual busy=%b done=%b we=%b div0=%b wa=%0d res=%h required all 0",
               bus.o_busy, bus.o_done, bus.o_we, bus.o_div0, bus.o_wa, bus.o_result);
    else passes++;
    reset = 1'b0;
    void'(expQ.pop_back());
    void'(startQ.pop_back());
    cycles(1);
    issue(2'd1, 16'(-100), 16'd7, 4'd2);
    waitObs(got);
    ex = expQ.pop_front();
    st = startQ.pop_front();
    checks++;
    if (!got) $display("[TB] FAIL after_abort: actual=no done required=done within bound");
    else begin
      ob  = obsQ.pop_front();
      act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
      if (act !== ex)
        $display("[TB] FAIL after_abort: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                 act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
      else passes++;
    end
    cycles(1);
  endtask

  task automatic test_back_to_back;
    vec_t v[$];
    rec_t ex;
    rec_t act;
    obs_t ob;
    int   st;
    bit   got;
    v.push_back('{2'd0, 16'(-3), 16'd7, 4'd4});
    v.push_back('{2'd1, 16'd1000, 16'(-3), 4'd7});
    v.push_back('{2'd2, 16'd1000, 16'(-3), 4'd8});
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].wa);
      waitObs(got);
      ex = expQ.pop_front();
      st = startQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL b2b[%0d]: actual=no done required=done within bound", i);
      else begin
        ob  = obsQ.pop_front();
        act = {ob.result, ob.div0, ob.we, ob.wa, 8'(ob.cyc - st)};
        if (act !== ex)
          $display("[TB] FAIL b2b[%0d]: actual res=%h div0=%b we=%b wa=%0d lat=%0d required res=%h div0=%b we=%b wa=%0d lat=%0d",
                   i, act.result, act.div0, act.we, act.wa, act.lat, ex.result, ex.div0, ex.we, ex.wa, ex.lat);
        else passes++;
      end
      cycles(1);
      checks++;
      if (bus.o_busy !== 1'b0) $display("[TB] FAIL b2b_idle[%0d]: actual busy=%b required 0", i, bus.o_busy); else passes++;
    end
  endtask

  initial begin
    $display("[TB] muldiv_unit bench starting");
    test_reset();
    test_busy_timing();
    test_mul();
    test_div();
    test_wa_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
